// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
package sim_run_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_e;

  localparam int unsigned HALT_CODE_W = 32;
  localparam logic [HALT_CODE_W-1:0] PASS_CODE = '0;

endpackage

// File: rtl/sim_run_ctrl_tracker.sv
// Per-hart retire counter and first-wins halt/exit-code latch.
module hart_halt_tracker
  import sim_run_pkg::*;
#(
  parameter int unsigned CYC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   count_en,
  input  logic                   halt_en,
  input  logic                   retire_i,
  input  logic                   halt_i,
  input  logic [HALT_CODE_W-1:0] halt_code_i,
  output logic [CYC_W-1:0]       retire_cnt_o,
  output logic                   halted_o,
  output logic [HALT_CODE_W-1:0] halt_code_o,
  output logic                   fail_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_o <= '0;
      halted_o     <= 1'b0;
      halt_code_o  <= '0;
      fail_o       <= 1'b0;
    end else begin
      if (count_en && retire_i && (retire_cnt_o != '1))
        retire_cnt_o <= retire_cnt_o + 1'b1;
      if (halt_en && halt_i && !halted_o) begin
        halted_o    <= 1'b1;
        halt_code_o <= halt_code_i;
        fail_o      <= (halt_code_i != PASS_CODE);
      end
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: CPU reset sequencing, run/drain FSM, cycle budget and halt collection.
// Optional progress watchdog enabled by SIM_RUN_CTRL_PROGRESS_WDT_EN.
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int unsigned NUM_HARTS    = 1,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CYC_W        = 32,
  parameter int unsigned STALL_LIMIT  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_HARTS-1:0]             retire_i,
  input  logic [NUM_HARTS-1:0]             halt_i,
  input  logic [NUM_HARTS*HALT_CODE_W-1:0] halt_code_i,
  output logic                             cpu_rst_n,
  output logic [1:0]                       state_o,
  output logic [CYC_W-1:0]                 cycle_cnt_o,
  output logic [NUM_HARTS*CYC_W-1:0]       retire_cnt_o,
  output logic [NUM_HARTS*HALT_CODE_W-1:0] halt_code_o,
  output logic [NUM_HARTS-1:0]             halted_o,
  output logic [NUM_HARTS-1:0]             fail_mask_o,
  output logic                             done_o,
  output logic                             pass_o,
  output logic                             timeout_o,
  output logic                             stall_o
);

  run_state_e  state_q, state_d;
  logic [31:0] hold_cnt, drain_cnt;
  logic        in_run, count_en;
  logic        all_halted_now, timeout_hit, stall_hit;
  logic        set_tmo, set_stl;

  assign in_run   = (state_q == RUN);
  assign count_en = in_run || (state_q == DRAIN);
  assign state_o  = state_q;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    hart_halt_tracker #(.CYC_W(CYC_W)) u_trk (
      .clk          (clk),
      .rst          (rst),
      .count_en     (count_en),
      .halt_en      (in_run),
      .retire_i     (retire_i[h]),
      .halt_i       (halt_i[h]),
      .halt_code_i  (halt_code_i[h*HALT_CODE_W +: HALT_CODE_W]),
      .retire_cnt_o (retire_cnt_o[h*CYC_W +: CYC_W]),
      .halted_o     (halted_o[h]),
      .halt_code_o  (halt_code_o[h*HALT_CODE_W +: HALT_CODE_W]),
      .fail_o       (fail_mask_o[h])
    );
  end

  // Halts accepted on this same edge count towards the all-halted exit.
  assign all_halted_now = &(halted_o | halt_i);
  assign timeout_hit    = (cycle_cnt_o == CYC_W'(MAX_CYCLES - 1));

`ifdef SIM_RUN_CTRL_PROGRESS_WDT_EN
  logic [31:0] idle_cnt;
  logic        stall_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q == HOLD)) begin
      idle_cnt <= '0;
    end else if (in_run) begin
      if (|retire_i)
        idle_cnt <= '0;
      else if (idle_cnt != '1)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= 1'b0;
    else     stall_q <= stall_q | set_stl;
  end

  assign stall_hit = (idle_cnt >= STALL_LIMIT);
  assign stall_o   = stall_q;
`else
  logic unused_stall_limit;
  assign unused_stall_limit = ^STALL_LIMIT;
  assign stall_hit = 1'b0;
  assign stall_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    set_tmo = 1'b0;
    set_stl = 1'b0;
    case (state_q)
      HOLD:  if (hold_cnt == RESET_CYCLES) state_d = RUN;
      RUN: begin
        if (all_halted_now) begin
          state_d = DRAIN;
        end else if (timeout_hit) begin
          state_d = DRAIN;
          set_tmo = 1'b1;
        end else if (stall_hit) begin
          state_d = DRAIN;
          set_stl = 1'b1;
        end
      end
      DRAIN: if (drain_cnt == DRAIN_CYCLES - 1) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= HOLD;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt    <= '0;
      drain_cnt   <= '0;
      cycle_cnt_o <= '0;
      cpu_rst_n   <= 1'b0;
      timeout_o   <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
    end else begin
      if (state_q == HOLD)  hold_cnt  <= hold_cnt + 1'b1;
      if (state_q == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      if (count_en && (cycle_cnt_o != '1))
        cycle_cnt_o <= cycle_cnt_o + 1'b1;
      cpu_rst_n <= (state_d != HOLD);
      timeout_o <= timeout_o | set_tmo;
      if ((state_q == DRAIN) && (state_d == DONE)) begin
        done_o <= 1'b1;
        pass_o <= (&halted_o) && !timeout_o && !stall_o && (fail_mask_o == '0);
      end
    end
  end

endmodule
